// File: rtl/dispatch_router_if.sv
`default_nettype none
// ============================================================================
//  dispatch_router_if
//  Shared instruction type plus the rename / ROB / RS handshake bundle used
//  by dispatch_router.
//  Revision: 1.0 - initial release
// ============================================================================

package dispatch_router_pkg;

    // Major opcodes (RV32 encoding)
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Reservation station selectors
    localparam logic [1:0] RS_ALU = 2'd0;
    localparam logic [1:0] RS_LSU = 2'd1;
    localparam logic [1:0] RS_BRU = 2'd2;

    // Renamed instruction; tag fields are sized for 64 physical registers
    typedef struct packed {
        logic [6:0]  opcode;
        logic [5:0]  prd;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic [15:0] imm;
    } instruction_t;

endpackage

interface dispatch_router_if #(
    parameter int ROB_WIDTH = 4
);
    import dispatch_router_pkg::*;

    // Rename side
    instruction_t           in_instruction_0;
    logic                   in_valid_0;
    instruction_t           in_instruction_1;
    logic                   in_valid_1;
    logic [1:0]             accept_count;

    // ROB side
    logic [ROB_WIDTH:0]     rob_free_count;
    logic [1:0]             rob_alloc_count;
    logic                   flush;
    logic [ROB_WIDTH-1:0]   flush_rob_tail;

    // Credit returns
    logic                   issue_valid_alu;
    logic                   issue_valid_lsu;
    logic                   issue_valid_bru;

    // RS dispatch ports
    instruction_t           alu_instruction_0, alu_instruction_1;
    logic [ROB_WIDTH-1:0]   alu_rob_id_0,      alu_rob_id_1;
    logic                   alu_valid_0,       alu_valid_1;
    instruction_t           lsu_instruction_0, lsu_instruction_1;
    logic [ROB_WIDTH-1:0]   lsu_rob_id_0,      lsu_rob_id_1;
    logic                   lsu_valid_0,       lsu_valid_1;
    instruction_t           bru_instruction_0, bru_instruction_1;
    logic [ROB_WIDTH-1:0]   bru_rob_id_0,      bru_rob_id_1;
    logic                   bru_valid_0,       bru_valid_1;

    // Router view
    modport slave (
        input  in_instruction_0, in_valid_0, in_instruction_1, in_valid_1,
        input  rob_free_count, flush, flush_rob_tail,
        input  issue_valid_alu, issue_valid_lsu, issue_valid_bru,
        output accept_count, rob_alloc_count,
        output alu_instruction_0, alu_rob_id_0, alu_valid_0,
        output alu_instruction_1, alu_rob_id_1, alu_valid_1,
        output lsu_instruction_0, lsu_rob_id_0, lsu_valid_0,
        output lsu_instruction_1, lsu_rob_id_1, lsu_valid_1,
        output bru_instruction_0, bru_rob_id_0, bru_valid_0,
        output bru_instruction_1, bru_rob_id_1, bru_valid_1
    );

    // Rename / ROB / RS view
    modport master (
        output in_instruction_0, in_valid_0, in_instruction_1, in_valid_1,
        output rob_free_count, flush, flush_rob_tail,
        output issue_valid_alu, issue_valid_lsu, issue_valid_bru,
        input  accept_count, rob_alloc_count,
        input  alu_instruction_0, alu_rob_id_0, alu_valid_0,
        input  alu_instruction_1, alu_rob_id_1, alu_valid_1,
        input  lsu_instruction_0, lsu_rob_id_0, lsu_valid_0,
        input  lsu_instruction_1, lsu_rob_id_1, lsu_valid_1,
        input  bru_instruction_0, bru_rob_id_0, bru_valid_0,
        input  bru_instruction_1, bru_rob_id_1, bru_valid_1
    );

endinterface

`default_nettype wire

// File: rtl/dispatch_router.sv
`default_nettype none
// ============================================================================
//  dispatch_router
//  Takes up to two renamed instructions per cycle, allocates ROB ids, steers
//  each to the ALU / LSU / BRU reservation station and registers the dual
//  dispatch ports. Credit counters and the ROB free count gate acceptance.
//  Revision: 1.0 - initial release
// ============================================================================

module dispatch_router
    import dispatch_router_pkg::*;
#(
    parameter int NUM_RS_ENTRIES = 8,
    parameter int ROB_WIDTH      = 4,
    parameter int PHY_REGS       = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,    // asynchronous, active low
    dispatch_router_if.slave  bus
);

    localparam int              CW         = $clog2(NUM_RS_ENTRIES) + 1;
    localparam int              FW         = ROB_WIDTH + 1;
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(NUM_RS_ENTRIES);

    // Tag fields of instruction_t are 6 bits; a larger register file needs a
    // wider instruction type, so this block only exists as a marker.
    if (PHY_REGS > 64) begin : g_phy_regs_exceed_tag
    end

    logic [CW-1:0]        credit_q [3];
    logic [CW-1:0]        credit_d [3];
    logic [ROB_WIDTH-1:0] rob_tail_q, rob_tail_d;
    instruction_t         inst_q   [3][2];
    logic [ROB_WIDTH-1:0] rob_id_q [3][2];
    logic                 valid_q  [3][2];

    logic [1:0]           tgt0, tgt1;
    logic [CW-1:0]        need1;
    logic                 acc0, acc1, port1;
    logic [1:0]           acc_cnt;
    logic [2:0]           issue;
    logic [CW:0]          dec, sum;

    function automatic logic [1:0] classify(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE:           classify = RS_LSU;
            OPC_BRANCH, OPC_JAL, OPC_JALR: classify = RS_BRU;
            default:                       classify = RS_ALU;
        endcase
    endfunction

    // Classification and in-order acceptance; slot 1 never goes alone
    always_comb begin
        tgt0    = classify(bus.in_instruction_0.opcode);
        tgt1    = classify(bus.in_instruction_1.opcode);
        need1   = (tgt1 == tgt0) ? CW'(2) : CW'(1);
        acc0    = rst && bus.in_valid_0 && !bus.flush
                  && (bus.rob_free_count >= FW'(1))
                  && (credit_q[tgt0] >= CW'(1));
        acc1    = acc0 && bus.in_valid_1
                  && (bus.rob_free_count >= FW'(2))
                  && (credit_q[tgt1] >= need1);
        port1   = (tgt1 == tgt0);
        acc_cnt = 2'(acc0) + 2'(acc1);
    end

    assign bus.accept_count    = acc_cnt;
    assign bus.rob_alloc_count = acc_cnt;
    assign issue = {bus.issue_valid_bru, bus.issue_valid_lsu, bus.issue_valid_alu};

    // Credit update: minus dispatches, plus returns, saturating at full
    always_comb begin
        dec = '0;
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            dec = (CW+1)'(acc0 && (tgt0 == 2'(r))) + (CW+1)'(acc1 && (tgt1 == 2'(r)));
            sum = {1'b0, credit_q[r]} + (CW+1)'(issue[r]) - dec;
            credit_d[r] = (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[CW-1:0];
        end
        rob_tail_d = rob_tail_q + ROB_WIDTH'(acc_cnt);
    end

    // Dispatch registers, credits and ROB tail; valids are one-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_tail_q <= '0;
            for (int r = 0; r < 3; r++) begin
                credit_q[r] <= CREDIT_MAX;
                for (int p = 0; p < 2; p++) begin
                    inst_q[r][p]   <= '0;
                    rob_id_q[r][p] <= '0;
                    valid_q[r][p]  <= 1'b0;
                end
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int p = 0; p < 2; p++) begin
                    valid_q[r][p] <= 1'b0;
                end
            end
            if (bus.flush) begin
                // RSs flush together with us, so every credit comes back
                rob_tail_q <= bus.flush_rob_tail;
                for (int r = 0; r < 3; r++) begin
                    credit_q[r] <= CREDIT_MAX;
                end
            end else begin
                rob_tail_q <= rob_tail_d;
                for (int r = 0; r < 3; r++) begin
                    credit_q[r] <= credit_d[r];
                end
                if (acc0) begin
                    inst_q[tgt0][0]   <= bus.in_instruction_0;
                    rob_id_q[tgt0][0] <= rob_tail_q;
                    valid_q[tgt0][0]  <= 1'b1;
                end
                // Second instruction takes port 1 only when sharing the RS
                if (acc1) begin
                    inst_q[tgt1][port1]   <= bus.in_instruction_1;
                    rob_id_q[tgt1][port1] <= rob_tail_q + ROB_WIDTH'(1);
                    valid_q[tgt1][port1]  <= 1'b1;
                end
            end
        end
    end

    assign bus.alu_instruction_0 = inst_q[0][0];
    assign bus.alu_instruction_1 = inst_q[0][1];
    assign bus.alu_rob_id_0      = rob_id_q[0][0];
    assign bus.alu_rob_id_1      = rob_id_q[0][1];
    assign bus.alu_valid_0       = valid_q[0][0];
    assign bus.alu_valid_1       = valid_q[0][1];
    assign bus.lsu_instruction_0 = inst_q[1][0];
    assign bus.lsu_instruction_1 = inst_q[1][1];
    assign bus.lsu_rob_id_0      = rob_id_q[1][0];
    assign bus.lsu_rob_id_1      = rob_id_q[1][1];
    assign bus.lsu_valid_0       = valid_q[1][0];
    assign bus.lsu_valid_1       = valid_q[1][1];
    assign bus.bru_instruction_0 = inst_q[2][0];
    assign bus.bru_instruction_1 = inst_q[2][1];
    assign bus.bru_rob_id_0      = rob_id_q[2][0];
    assign bus.bru_rob_id_1      = rob_id_q[2][1];
    assign bus.bru_valid_0       = valid_q[2][0];
    assign bus.bru_valid_1       = valid_q[2][1];

endmodule

`default_nettype wire

// File: tb/tb_dispatch_router.sv
`default_nettype none
// ============================================================================
//  tb_dispatch_router
//  Self-checking bench: a table of dispatch vectors with expected accept
//  counts and targets, a queue of expected registered outputs, and hand
//  sequences for flush and asynchronous reset.
//  Revision: 1.0 - initial release
// ============================================================================

module tb_dispatch_router;
    import dispatch_router_pkg::*;

    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dispatch_router_if #(.ROB_WIDTH(RW)) bus ();

    dispatch_router #(
        .NUM_RS_ENTRIES (8),
        .ROB_WIDTH      (RW),
        .PHY_REGS       (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One dispatch vector: inputs plus hand-derived accept count and targets
    typedef struct packed {
        logic [6:0] op0;
        logic       v0;
        logic [6:0] op1;
        logic       v1;
        logic [4:0] free;
        logic [2:0] iss;   // {bru, lsu, alu}
        logic [1:0] acc;
        logic [1:0] t0;
        logic [1:0] t1;
    } vec_t;

    // Registered outputs, index = rs*2 + port
    typedef struct packed {
        logic [5:0]                valid;
        logic [5:0][RW-1:0]        id;
        instruction_t [5:0]        inst;
    } outs_t;

    outs_t          sb_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [RW-1:0]  m_tail   = '0;
    vec_t           vecs[20];

    function automatic outs_t sample();
        outs_t o;
        o.valid = {bus.bru_valid_1, bus.bru_valid_0, bus.lsu_valid_1,
                   bus.lsu_valid_0, bus.alu_valid_1, bus.alu_valid_0};
        o.id    = {bus.bru_rob_id_1, bus.bru_rob_id_0, bus.lsu_rob_id_1,
                   bus.lsu_rob_id_0, bus.alu_rob_id_1, bus.alu_rob_id_0};
        o.inst  = {bus.bru_instruction_1, bus.bru_instruction_0, bus.lsu_instruction_1,
                   bus.lsu_instruction_0, bus.alu_instruction_1, bus.alu_instruction_0};
        return o;
    endfunction

    task automatic idle_bus();
        bus.in_valid_0      = 1'b0;
        bus.in_valid_1      = 1'b0;
        bus.flush           = 1'b0;
        bus.flush_rob_tail  = '0;
        bus.issue_valid_alu = 1'b0;
        bus.issue_valid_lsu = 1'b0;
        bus.issue_valid_bru = 1'b0;
    endtask

    task automatic check_acc(input string name, input logic [1:0] exp);
        n_checks++;
        if (bus.accept_count !== exp || bus.rob_alloc_count !== exp) begin
            n_fail++;
            $display("FAIL %s: accept_count=%0d rob_alloc_count=%0d, expected %0d",
                     name, bus.accept_count, bus.rob_alloc_count, exp);
        end
    endtask

    task automatic check_outs(input string name, input outs_t exp, input bit full);
        outs_t act;
        bit    ok;
        act = sample();
        ok  = (act.valid === exp.valid);
        for (int p = 0; p < 6; p++) begin
            if (full || exp.valid[p]) begin
                if (act.id[p] !== exp.id[p] || act.inst[p] !== exp.inst[p]) ok = 1'b0;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: valid=%b ids=%h, expected valid=%b ids=%h",
                     name, act.valid, act.id, exp.valid, exp.id);
        end
    endtask

    // Drive one cycle, predict, then compare the registered result
    task automatic do_step(input vec_t v, input logic fl, input logic [RW-1:0] ft, input int idx);
        instruction_t i0, i1;
        outs_t        e;
        int           p;
        i0 = '{opcode: v.op0, prd: 6'(idx), prs1: 6'(idx + 1), prs2: 6'(idx + 2), imm: 16'(16'hA000 + idx)};
        i1 = '{opcode: v.op1, prd: 6'(idx + 3), prs1: 6'(idx + 4), prs2: 6'(idx + 5), imm: 16'(16'hB000 + idx)};
        bus.in_instruction_0 = i0;
        bus.in_instruction_1 = i1;
        bus.in_valid_0       = v.v0;
        bus.in_valid_1       = v.v1;
        bus.rob_free_count   = v.free;
        bus.flush            = fl;
        bus.flush_rob_tail   = ft;
        bus.issue_valid_alu  = v.iss[0];
        bus.issue_valid_lsu  = v.iss[1];
        bus.issue_valid_bru  = v.iss[2];
        #1;
        check_acc($sformatf("accept step %0d", idx), v.acc);
        e = '0;
        if (v.acc >= 2'd1) begin
            p = int'(v.t0) * 2;
            e.valid[p] = 1'b1;
            e.id[p]    = m_tail;
            e.inst[p]  = i0;
        end
        if (v.acc == 2'd2) begin
            p = int'(v.t1) * 2 + ((v.t1 == v.t0) ? 1 : 0);
            e.valid[p] = 1'b1;
            e.id[p]    = m_tail + RW'(1);
            e.inst[p]  = i1;
        end
        sb_q.push_back(e);
        m_tail = fl ? ft : m_tail + RW'(v.acc);
        @(posedge clk);
        #1;
        idle_bus();
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard step %0d: queue empty, expected one entry", idx);
        end else begin
            check_outs($sformatf("dispatch step %0d", idx), sb_q.pop_front(), 1'b0);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] o0, input logic [6:0] o1, input logic [1:0] acc,
                                input logic [1:0] t0, input logic [1:0] t1);
        vec_t v;
        v = '{op0: o0, v0: 1'b1, op1: o1, v1: 1'b1, free: 5'd16, iss: 3'b000,
              acc: acc, t0: t0, t1: t1};
        return v;
    endfunction

    initial begin
        vec_t v;

        // Credits start 8/8/8, ROB tail 0; comments give state after the step
        vecs[0]  = mk(OPC_OP,     OPC_OP,     2, RS_ALU, RS_ALU);  // ids 0,1  alu 6
        vecs[1]  = mk(OPC_LOAD,   OPC_BRANCH, 2, RS_LSU, RS_BRU);  // ids 2,3
        vecs[2]  = mk(OPC_OP,     OPC_OP,     2, RS_ALU, RS_ALU);  // alu 4
        vecs[3]  = mk(OPC_OP,     OPC_OP,     2, RS_ALU, RS_ALU);  // alu 2
        vecs[4]  = mk(OPC_OP,     OPC_OP,     2, RS_ALU, RS_ALU);  // alu 0, tail 10
        vecs[5]  = mk(OPC_OP,     OPC_LOAD,   0, RS_ALU, RS_LSU);  // stall
        vecs[6]  = mk(OPC_OP,     OPC_LOAD,   0, RS_ALU, RS_LSU);  vecs[6].iss = 3'b001;
        vecs[7]  = mk(OPC_OP,     OPC_LOAD,   2, RS_ALU, RS_LSU);  // ids 10,11
        vecs[8]  = mk(OPC_JAL,    OPC_LOAD,   2, RS_BRU, RS_LSU);  vecs[8].iss = 3'b001;
        vecs[9]  = mk(OPC_STORE,  OPC_OP,     1, RS_LSU, RS_ALU);  vecs[9].iss = 3'b001; vecs[9].v1 = 1'b0;
        vecs[10] = mk(OPC_OP,     OPC_OP,     2, RS_ALU, RS_ALU);  // ids 15,0 wrap
        vecs[11] = mk(OPC_SYSTEM, OPC_OP_IMM, 0, RS_ALU, RS_ALU);  vecs[11].iss = 3'b001;
        vecs[12] = mk(OPC_SYSTEM, OPC_OP_IMM, 1, RS_ALU, RS_ALU);  // alu credit 1 only
        vecs[13] = mk(OPC_LOAD,   OPC_BRANCH, 1, RS_LSU, RS_BRU);  vecs[13].iss = 3'b001; vecs[13].free = 5'd1;
        vecs[14] = mk(OPC_BRANCH, OPC_LOAD,   0, RS_BRU, RS_LSU);  vecs[14].free = 5'd0;
        vecs[15] = mk(7'h7F,      OPC_JALR,   2, RS_ALU, RS_BRU);  vecs[15].free = 5'd2;
        vecs[16] = mk(OPC_LUI,    OPC_AUIPC,  0, RS_ALU, RS_ALU);  vecs[16].iss = 3'b111; vecs[16].v0 = 1'b0; vecs[16].v1 = 1'b0;
        vecs[17] = mk(OPC_JALR,   OPC_BRANCH, 2, RS_BRU, RS_BRU);  // ids 5,6
        vecs[18] = mk(OPC_LOAD,   OPC_STORE,  2, RS_LSU, RS_LSU);  // ids 7,8
        vecs[19] = mk(OPC_LUI,    OPC_JAL,    2, RS_ALU, RS_BRU);  vecs[19].iss = 3'b001;

        // Reset state, with a valid instruction offered to prove gating
        idle_bus();
        bus.rob_free_count   = 5'd16;
        bus.in_instruction_0 = '{opcode: OPC_OP, prd: 6'd1, prs1: 6'd2, prs2: 6'd3, imm: 16'h1234};
        bus.in_instruction_1 = '0;
        bus.in_valid_0       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_acc("accept in reset", 2'd0);
        check_outs("outputs in reset", '0, 1'b1);
        idle_bus();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            do_step(vecs[i], 1'b0, '0, i);
        end

        // Flush while a dispatch is registered
        do_step(mk(OPC_BRANCH, OPC_LOAD, 2, RS_BRU, RS_LSU), 1'b0, '0, 100);  // ids 11,12
        v = mk(OPC_OP, OPC_OP, 0, RS_ALU, RS_ALU);
        v.iss = 3'b100;
        do_step(v, 1'b1, RW'(5), 101);
        do_step(mk(OPC_OP, OPC_OP, 2, RS_ALU, RS_ALU), 1'b0, '0, 102);        // ids 5,6
        for (int i = 0; i < 4; i++) begin
            do_step(mk(OPC_JAL, OPC_JALR, 2, RS_BRU, RS_BRU), 1'b0, '0, 103 + i);
        end
        do_step(mk(OPC_JAL, OPC_JAL, 0, RS_BRU, RS_BRU), 1'b0, '0, 107);     // bru exhausted

        // Asynchronous reset between edges while valids are high
        do_step(mk(OPC_OP, OPC_OP, 2, RS_ALU, RS_ALU), 1'b0, '0, 200);
        bus.in_instruction_0 = '{opcode: OPC_OP, prd: 6'd9, prs1: 6'd9, prs2: 6'd9, imm: 16'h0009};
        bus.in_valid_0       = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_acc("accept after async reset", 2'd0);
        check_outs("outputs after async reset", '0, 1'b1);
        idle_bus();
        @(negedge clk);
        rst    = 1'b1;
        m_tail = '0;
        for (int i = 0; i < 4; i++) begin
            do_step(mk(OPC_OP, OPC_OP, 2, RS_ALU, RS_ALU), 1'b0, '0, 201 + i);  // ids from 0
        end
        do_step(mk(OPC_OP, OPC_OP, 0, RS_ALU, RS_ALU), 1'b0, '0, 205);          // alu exhausted

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
